// File: rtl/mc_prog_seq.sv
// Program buffer and replay sequencer: loads MC instruction words from the host
// FIFO into distributed RAM, then replays them to MC for N passes or until stopped.
module mc_prog_seq #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_en,
  input  logic          run,
  input  logic          stop,
  input  logic [15:0]   repeat_n,
  input  logic          host_empty,
  output logic          host_rd,
  input  logic [DW-1:0] host_din,
  output logic          mc_empty,
  input  logic          mc_rd,
  output logic [DW-1:0] mc_dout,
  output logic [AW:0]   prog_len,
  output logic [15:0]   pass_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   prog_len_q;
  logic [AW-1:0] ptr_q;
  logic [15:0]   pass_cnt_q;
  logic [15:0]   repeat_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          prog_full;
  logic          mem_we;
  logic          last_word;
  logic [15:0]   pass_inc;

  // prog_len reaches DEPTH exactly when its top bit is set
  assign prog_full = prog_len_q[AW];
  assign host_rd   = (state_q == LOAD) && !host_empty && !rst;
  assign mem_we    = host_rd && !prog_full;
  assign last_word = ({1'b0, ptr_q} == (prog_len_q - 1'b1));
  assign pass_inc  = pass_cnt_q + 16'd1;

  assign mc_empty  = (state_q != RUN);
  assign mc_dout   = mc_empty ? '0 : mem_q[ptr_q];
  assign prog_len  = prog_len_q;
  assign pass_cnt  = pass_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // Program store is deliberately left uninitialised across reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[prog_len_q[AW-1:0]] <= host_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      ptr_q      <= '0;
      pass_cnt_q <= '0;
      repeat_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (prog_en) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            prog_len_q <= '0;
            err_q      <= 1'b0;
          end else if (run) begin
            if (prog_len_q != '0) begin
              state_q    <= RUN;
              busy_q     <= 1'b1;
              ptr_q      <= '0;
              pass_cnt_q <= '0;
              repeat_q   <= repeat_n;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // Overflow words are still popped so the host FIFO drains
          if (host_rd) begin
            if (prog_full) err_q <= 1'b1;
            else           prog_len_q <= prog_len_q + 1'b1;
          end
          if (!prog_en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (mc_rd) begin
            if (!last_word) begin
              ptr_q <= ptr_q + 1'b1;
            end else begin
              pass_cnt_q <= pass_inc;
              if ((repeat_q != 16'd0) && (pass_inc == repeat_q)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                ptr_q <= '0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_prog_seq.sv
// Randomized scoreboard bench for mc_prog_seq: load/replay against a queue/array model.
module tb_mc_prog_seq;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          prog_en;
  logic          run;
  logic          stop;
  logic [15:0]   repeat_n;
  logic          host_empty;
  logic          host_rd;
  logic [DW-1:0] host_din;
  logic          mc_empty;
  logic          mc_rd;
  logic [DW-1:0] mc_dout;
  logic [AW:0]   prog_len;
  logic [15:0]   pass_cnt;
  logic          busy;
  logic          done;
  logic          err;

  mc_prog_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .prog_en(prog_en), .run(run), .stop(stop),
    .repeat_n(repeat_n), .host_empty(host_empty), .host_rd(host_rd),
    .host_din(host_din), .mc_empty(mc_empty), .mc_rd(mc_rd), .mc_dout(mc_dout),
    .prog_len(prog_len), .pass_cnt(pass_cnt), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [31:0] mem_m [DEPTH];
  int          model_len = 0;
  bit          model_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] hq [$];
  logic [31:0] mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every word MC actually consumes is matched against the scoreboard
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (!rst && !stop && !mc_empty && mc_rd) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word: got 0x%0h want none", mc_dout);
      end else begin
        mon_w = exp_q.pop_front();
        chk("mc_dout", mc_dout, mon_w);
      end
    end
  end

  task automatic check_reset();
    chk("rst_host_rd", host_rd, 0);
    chk("rst_mc_empty", mc_empty, 1);
    chk("rst_mc_dout", mc_dout, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic do_load(input int n, input logic [31:0] base, input bit gaps, input bit poke_run);
    int cyc;
    logic [31:0] w;
    hq.delete();
    for (int i = 0; i < n; i++) hq.push_back((base != 0) ? base + i : $urandom());
    prog_en = 1'b1;
    @(posedge clk); #1;
    model_len = 0;
    model_err = 0;
    chk("load_busy", busy, 1);
    chk("load_len_clr", prog_len, 0);
    chk("load_err_clr", err, 0);
    cyc = 0;
    while (hq.size() > 0 && cyc < 5000) begin
      host_empty = gaps && ($urandom_range(0, 3) == 0);
      host_din   = hq[0];
      run        = poke_run && (cyc == 1);
      #1;
      chk("host_rd", host_rd, !host_empty);
      if (poke_run) chk("load_mc_empty", mc_empty, 1);
      @(posedge clk);
      if (!host_empty) begin
        w = hq.pop_front();
        if (model_len < DEPTH) begin
          mem_m[model_len] = w;
          model_len++;
        end else begin
          model_err = 1;
        end
      end
      #1;
      cyc++;
    end
    if (cyc >= 5000) begin
      total++; bad++;
      $display("FAIL load_timeout: got %0d cycles want <5000", cyc);
    end
    host_empty = 1'b1;
    host_din   = '0;
    run        = 1'b0;
    prog_en    = 1'b0;
    @(posedge clk); #1;
    chk("load_prog_len", prog_len, model_len);
    chk("load_err", err, model_err);
    chk("load_exit_busy", busy, 0);
    chk("load_exit_mc_empty", mc_empty, 1);
    $display("load: offered=%0d prog_len=%0d err=%0b", n, prog_len, err);
  endtask

  // mode 0: run to completion, 1: stop after nreads, 2: reset after nreads
  task automatic do_run(input int rep, input int nreads, input int mode, input int gap_pct);
    int reads;
    int cyc;
    int len;
    len = model_len;
    for (int i = 0; i < nreads; i++) exp_q.push_back(mem_m[i % len]);
    repeat_n = rep[15:0];
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    chk("run_mc_empty", mc_empty, 0);
    chk("run_first_word", mc_dout, mem_m[0]);
    chk("run_busy", busy, 1);
    chk("run_pass_clr", pass_cnt, 0);
    reads = 0;
    cyc = 0;
    while (reads < nreads && cyc < 20000) begin
      mc_rd = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
      if (gap_pct == 0) chk("no_bubble", mc_empty, 0);
      @(posedge clk);
      if (mc_rd) reads++;
      #1;
      cyc++;
    end
    mc_rd = 1'b0;
    if (cyc >= 20000) begin
      total++; bad++;
      $display("FAIL run_timeout: got %0d reads want %0d", reads, nreads);
    end
    if (mode == 0) begin
      exp_done++;
      chk("end_done", done, 1);
      chk("end_mc_empty", mc_empty, 1);
      chk("end_busy", busy, 0);
      chk("end_pass_cnt", pass_cnt, rep);
      @(posedge clk); #1;
      chk("done_pulse_width", done, 0);
    end else if (mode == 1) begin
      stop  = 1'b1;
      mc_rd = 1'b1;
      @(posedge clk); #1;
      stop  = 1'b0;
      mc_rd = 1'b0;
      chk("stop_mc_empty", mc_empty, 1);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_pass_cnt", pass_cnt, nreads / len);
    end else begin
      rst   = 1'b1;
      stop  = 1'b1;
      mc_rd = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      stop  = 1'b0;
      mc_rd = 1'b0;
      check_reset();
      model_len = 0;
      model_err = 0;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("run: rep=%0d reads=%0d mode=%0d pass_cnt=%0d", rep, nreads, mode, pass_cnt);
  endtask

  initial begin
    int len;
    int rep;
    rst = 1'b1; prog_en = 1'b0; run = 1'b0; stop = 1'b0; repeat_n = '0;
    host_empty = 1'b1; host_din = '0; mc_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    // Run with an empty program completes immediately
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    exp_done++;
    chk("empty_run_done", done, 1);
    chk("empty_run_mc_empty", mc_empty, 1);
    chk("empty_run_busy", busy, 0);
    @(posedge clk); #1;
    chk("empty_run_done_clr", done, 0);
    $display("run: empty program done pulse checked");

    do_load(4, 32'hA0, 0, 1);
    do_run(3, 12, 0, 0);
    do_run(0, 10, 1, 0);

    do_load(DEPTH + 2, 32'h0, 1, 0);
    do_run(1, DEPTH, 0, 0);

    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 24);
      do_load(len, 32'h0, 1, 0);
      rep = $urandom_range(1, 3);
      do_run(rep, rep * len, 0, 30);
      do_run(0, $urandom_range(1, 3 * len), 1, 25);
    end

    do_load(4, 32'hB0, 0, 0);
    do_run(0, 5, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_prog_seq.md
# mc_prog_seq

Program buffer and replay sequencer placed between the host instruction FIFO and the memory controller (MC) instruction port. In load mode it captures a host-supplied program of 32-bit MC instruction words into internal distributed RAM. On a run command it replays the stored program to MC through a FIFO-style, first-word-fall-through interface, either a programmed number of passes or until stopped. Long pulse trains and repeated cycling can therefore run without host traffic.

## Interface
Parameters:
- AW, 8, address width; program depth DEPTH = 2^AW words
- DW, 32, instruction word width

Ports (one clock domain; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- prog_en  in  1  level; high = load mode
- run  in  1  single-cycle start pulse
- stop  in  1  single-cycle abort pulse
- repeat_n  in  16  pass count, sampled on accepted run; 0 = infinite
- host_empty  in  1  host FIFO empty (FWFT)
- host_rd  out  1  host FIFO pop strobe
- host_din  in  DW  host FIFO head word, valid while host_empty=0
- mc_empty  out  1  low = mc_dout valid
- mc_rd  in  1  MC consumes mc_dout (MC din_wr)
- mc_dout  out  DW  current instruction word; 0 while mc_empty=1
- prog_len  out  AW+1  stored program length in words
- pass_cnt  out  16  completed passes in current/last run
- busy  out  1  high in LOAD or RUN
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky overflow flag

## Operation
- States: IDLE, LOAD, RUN.
- Reset: state IDLE, host_rd=0, mc_empty=1, mc_dout=0, prog_len=0, pass_cnt=0, busy=0, done=0, err=0, read pointer 0. RAM contents are not cleared.
- IDLE:
  - prog_en=1 -> LOAD; prog_len cleared to 0; err cleared.
  - run=1 with prog_len>0 -> RUN; ptr=0; pass_cnt=0; repeat_n latched.
  - run=1 with prog_len=0 -> done pulse, stay IDLE.
  - prog_en has priority over run.
- LOAD:
  - host_rd = ~host_empty, combinational, every cycle.
  - On a pop with prog_len<DEPTH: write host_din to mem[prog_len], then prog_len+1.
  - On a pop with prog_len=DEPTH: discard the word, set err. The host FIFO is still drained.
  - prog_en=0 -> IDLE. run and stop are ignored.
- RUN:
  - mc_empty=0; mc_dout=mem[ptr] (asynchronous RAM read).
  - mc_rd=1 with ptr<prog_len-1: ptr+1.
  - mc_rd=1 with ptr=prog_len-1: pass_cnt+1.
    - If latched repeat_n≠0 and pass_cnt+1=repeat_n: -> IDLE, done pulse.
    - Otherwise ptr=0 and continue.
  - stop=1 -> IDLE. No done pulse; a simultaneous mc_rd is not counted.
  - prog_en and run are ignored; host_rd=0.
- Infinite mode: pass_cnt wraps 0xFFFF -> 0x0000.
- mc_rd while mc_empty=1 is ignored.

## Timing
- Load throughput: 1 word/cycle. host_rd and the write occur in the same cycle; prog_len updates the next cycle.
- run at cycle N: mc_empty=0 and mc_dout=mem[0] at N+1.
- Replay throughput: 1 word/cycle with mc_rd held high; no bubble at pass wrap.
- Last mc_rd at cycle K: done=1 and mc_empty=1 at K+1.
- stop at cycle N: mc_empty=1 and busy=0 at N+1.
- busy is registered with the state: high from the cycle after entry to LOAD/RUN until the cycle after exit.
- rst mid-LOAD or mid-RUN: all outputs return to reset values the next cycle; prog_len=0, so the program must be reloaded.

## Test plan
- Load 4 words 0xA0..0xA3 with host_empty low 4 cycles -> 4 host_rd pulses, prog_len=4, err=0.
- run with repeat_n=3 and mc_rd held high -> mc_dout sequence A0..A3 three times on 12 consecutive cycles; done pulse one cycle after the 12th read; pass_cnt=3.
- Load DEPTH+2 words -> prog_len=DEPTH, err=1, last 2 words discarded, host FIFO empty.
- run with repeat_n=0, stop after 10 reads of a 4-word program -> mc_empty=1 next cycle, no done, pass_cnt=2.
- run with prog_len=0 -> done pulse next cycle, mc_empty stays 1; run during LOAD -> ignored.
- rst asserted mid-RUN, including stop and mc_rd in the same cycle -> all outputs at reset values next cycle; prog_len=0.
